// File: rtl/multiplier_32_seq_if.sv
// Operand/result handshake bundle for the sequential 32x32 multiplier.
// master = producer/consumer side, slave = the multiplier.
interface multiplier_32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/multiplier_32_seq.sv
// Sequential 32x32 -> 64 unsigned multiplier built around one shared
// 16x16 multiplier; four partial products are accumulated over four cycles.
module multiplier_32_seq (
    input  logic                 clk,
    input  logic                 rst,
    multiplier_32_seq_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  step;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [63:0] acc;

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] pp;
    logic [63:0] pp_shifted;

    // Operand halves for the current step: step[1] picks A's upper half,
    // step[0] picks B's upper half; shift is the sum of both half offsets.
    always_comb begin
        op_a       = step[1] ? a_reg[31:16] : a_reg[15:0];
        op_b       = step[0] ? b_reg[31:16] : b_reg[15:0];
        pp_shifted = {32'd0, pp};
        case (step)
            2'd0:    pp_shifted = {32'd0, pp};
            2'd1,
            2'd2:    pp_shifted = {16'd0, pp, 16'd0};
            default: pp_shifted = {pp, 32'd0};
        endcase
    end

    mul16_unsigned u_mul16 (
        .a (op_a),
        .b (op_b),
        .p (pp)
    );

    // FSM, step counter, operand latch and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= 2'd0;
            acc   <= 64'd0;
            a_reg <= 32'd0;
            b_reg <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.A;
                        b_reg <= bus.B;
                        acc   <= 64'd0;
                        step  <= 2'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shifted;
                    // Wrap 3 -> 0 lands on the same edge as MUL -> DONE.
                    step <= step + 2'd1;
                    if (step == 2'd3)
                        state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.product   = acc;
endmodule

// The single shared 16x16 -> 32 unsigned multiplier.
module mul16_unsigned (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    assign p = 32'(a) * 32'(b);
endmodule

// File: tb/tb_multiplier_32_seq.sv
// Directed scoreboard bench for multiplier_32_seq.
module tb_multiplier_32_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplier_32_seq_if bus ();
    multiplier_32_seq dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] exp_q[$];
    time         t_acc[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with the DUT idle; returns just after the accept edge.
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [63:0] expv);
        check("accept_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        exp_q.push_back(expv);
        t_acc.push_back($time);
        @(posedge clk);
    endtask

    // Waits for the result while scrambling inputs, optionally holds it under
    // backpressure, then hands it off. Returns at a negedge in IDLE.
    task automatic collect(input int hold, input logic keep_iv, input logic tie_or);
        int          lat  = 0;
        bit          seen = 1'b0;
        logic [63:0] expv;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid  = keep_iv;
            bus.A         = $urandom;
            bus.B         = $urandom;
            bus.out_ready = tie_or;
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check("result_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat), 64'd4);
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        check("product", bus.product, expv);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            bus.A = $urandom;
            bus.B = $urandom;
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_product", bus.product, expv);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = tie_or;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_product", bus.product, 64'd0);

        // Corner operands
        accept(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001); collect(0, 1'b0, 1'b0);
        accept(32'h00010000, 32'h00010000, 64'h0000000100000000); collect(0, 1'b0, 1'b0);
        accept(32'h0000FFFF, 32'hFFFF0000, 64'h0000FFFE00010000); collect(0, 1'b0, 1'b0);
        accept(32'h00000000, 32'hDEADBEEF, 64'h0);                collect(0, 1'b0, 1'b0);
        // Inputs churn during MUL
        accept(32'h00000002, 32'h00000002, 64'h4);                collect(0, 1'b0, 1'b0);

        // Backpressure with a pending request behind it
        accept(32'h12345678, 32'h9ABCDEF0, model(32'h12345678, 32'h9ABCDEF0));
        collect(10, 1'b1, 1'b0);
        accept(32'hCAFEBABE, 32'h0BADF00D, model(32'hCAFEBABE, 32'h0BADF00D));
        collect(0, 1'b0, 1'b0);

        // Reset while step == 2
        accept(32'd7, 32'd9, 64'd63);
        @(negedge clk); bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_product", bus.product, 64'd0);
        accept(32'd3, 32'd5, 64'd15); collect(0, 1'b0, 1'b0);

        // Reset beats a simultaneous in_valid
        rst = 1'b1; bus.in_valid = 1'b1; bus.A = 32'h77; bus.B = 32'h77;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0;
        check("rst_vs_iv_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_vs_iv_product", bus.product, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("idle_stays_idle", 64'(bus.in_ready), 64'd1);

        // Back-to-back with in_valid and out_ready held high
        t_acc.delete();
        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom;
            accept(ra, rb, model(ra, rb));
            collect(0, 1'b1, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++)
            check("b2b_spacing", 64'(t_acc[k+1] - t_acc[k]), 64'd60);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/multiplier_32_seq.md
MULTIPLIER_32_SEQ -- requirements
Module: multiplier_32_seq

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port in_valid, input, 1 bit: operands A and B are presented.
REQ-005 Port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 Port A, input, 32 bits: unsigned multiplicand.
REQ-007 Port B, input, 32 bits: unsigned multiplier.
REQ-008 Port out_valid, output, 1 bit: product holds a finished result.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 Port product, output, 64 bits: unsigned A*B.
REQ-011 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 The block SHALL contain exactly one combinational 16x16->32 unsigned multiplier instance, shared across all partial products; no other multiply operator SHALL be used.
REQ-013 FSM states SHALL be IDLE, MUL, DONE, plus a 2-bit step counter used in MUL.
REQ-014 in_ready SHALL equal 1 only in IDLE; busy SHALL equal NOT in_ready.
REQ-015 Accept: in_valid=1 in IDLE at edge E0 SHALL latch A and B into internal registers, clear the 64-bit accumulator to 0, set step=0, and enter MUL.
REQ-016 in_valid=0 in IDLE SHALL leave the FSM in IDLE.
REQ-017 In MUL, one partial product per edge E1..E4 SHALL be added into the accumulator:
  - step0: A[15:0]*B[15:0], shifted left 0;
  - step1: A[15:0]*B[31:16], shifted left 16;
  - step2: A[31:16]*B[15:0], shifted left 16;
  - step3: A[31:16]*B[31:16], shifted left 32.
REQ-018 Each partial product SHALL be zero-extended to 64 bits before shifting, and the accumulator SHALL be 64 bits; the final sum cannot overflow.
REQ-019 At E4 (step3) the FSM SHALL enter DONE; out_valid SHALL be 1 in the cycle after E4 (4 cycles after the accept edge).
REQ-020 product SHALL be driven from the accumulator register; in DONE it SHALL equal A*B of the latched operands exactly.
REQ-021 In DONE, out_valid SHALL stay 1 and product SHALL stay stable until a cycle with out_ready=1.
REQ-022 out_valid=1 and out_ready=1 at an edge SHALL return the FSM to IDLE; out_valid=0 and in_ready=1 in the next cycle.
REQ-023 in_valid, A and B SHALL be ignored outside IDLE; input changes during MUL/DONE SHALL NOT affect the result.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 out_valid SHALL be 0 in IDLE and MUL.
REQ-026 Throughput with out_ready tied 1 and in_valid tied 1 SHALL be one result per 6 cycles: accept, 4 MUL edges, 1 DONE handshake edge.
REQ-027 The 2-bit step counter SHALL only be evaluated in MUL; wrap from 3 SHALL coincide with the MUL->DONE transition.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, step=0, accumulator=0 and operand registers=0, overriding every other input.
REQ-029 After reset: in_ready=1, busy=0, out_valid=0, product=64'h0.
REQ-030 Reset asserted during MUL or DONE SHALL abandon the operation with no result delivered; the next accept SHALL start cleanly.
REQ-031 rst and in_valid both high at the same edge: reset SHALL win and no operands SHALL be latched.

Verification
REQ-032 A=32'hFFFFFFFF, B=32'hFFFFFFFF accepted at E0 -> out_valid=1 in cycle after E4, product=64'hFFFFFFFE00000001.
REQ-033 A=32'h00010000, B=32'h00010000 -> product=64'h0000000100000000; A=32'h0000FFFF, B=32'hFFFF0000 -> product=64'h0000FFFE00010000; A=0, B=32'hDEADBEEF -> product=0.
REQ-034 Backpressure: out_ready=0 for 10 cycles after out_valid rises, with in_valid=1 and A/B toggling -> product constant, in_ready=0, out_valid=1; out_ready=1 -> IDLE the next cycle, then the pending in_valid is accepted.
REQ-035 Inputs change every cycle during MUL (A=B=32'h00000002 accepted, then driven to 32'hFFFFFFFF) -> product=64'h4.
REQ-036 rst=1 in the cycle at step2 -> next cycle in_ready=1, out_valid=0, product=0; a new accept of 3*5 -> product=64'd15 with no residue.
REQ-037 Back-to-back, out_ready=1 and in_valid=1 held for 3 operations -> accepts exactly 6 cycles apart; 3 correct products each valid for 1 cycle.
